// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM round-robin access controller.
//   arb_state_e : controller FSM states
//   *_DEF       : default parameter values for ram_rr_arbiter
//   idx_w()     : width of an index into n requesters (at least 1)
package ram_arb_pkg;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned AW_DEF    = 4;
  localparam int unsigned DW_DEF    = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate requests so that ptr sits at bit 0,
// find the first set bit, then rotate the result back.
//   req  in  N_REQ  request vector
//   ptr  in  IW     highest-priority requester index
//   gnt  out N_REQ  one-hot winner (zero when no request)
//   idx  out IW     encoded winner index
//   any  out 1      at least one request present
module rr_pick
  import ram_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  localparam int unsigned IW   = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             any
);

  logic [N_REQ-1:0] rot;

  always_comb begin
    int j;
    int first;
    logic found;
    j     = 0;
    first = 0;
    found = 1'b0;
    rot   = '0;
    gnt   = '0;
    any   = |req;
    // rot[i] = req[(ptr + i) mod N_REQ]
    for (int i = 0; i < int'(N_REQ); i++) begin
      j = i + int'(ptr);
      if (j >= int'(N_REQ)) j = j - int'(N_REQ);
      rot[i] = req[j];
    end
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        first = i;
      end
    end
    // rotate back into requester numbering
    j = first + int'(ptr);
    if (j >= int'(N_REQ)) j = j - int'(N_REQ);
    idx = IW'(j);
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/ram_rr_arbiter.sv
// Round-robin access controller sharing one RAM port among N_REQ requesters.
// One transaction at a time: IDLE -> ACCESS -> (WAIT) -> DONE -> IDLE.
//   clk, rst            clock, async active-high reset
//   req/req_we          per-requester request level and write flag
//   req_ad/req_wdata    flattened per-requester address and write data
//   gnt                 one-hot grant held for the whole transaction
//   done                one-cycle completion pulse to the granted requester
//   rdata               last read result (updated only by reads)
//   busy                controller not in IDLE
//   ram_ad/ram_we/ram_re/ram_wdata/ram_rdata   RAM port
module ram_rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DW    = DW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    req_we,
  input  logic [N_REQ*AW-1:0] req_ad,
  input  logic [N_REQ*DW-1:0] req_wdata,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    done,
  output logic [DW-1:0]       rdata,
  output logic                busy,
  output logic [AW-1:0]       ram_ad,
  output logic                ram_we,
  output logic                ram_re,
  output logic [DW-1:0]       ram_wdata,
  input  logic [DW-1:0]       ram_rdata
);

  localparam int unsigned IW = idx_w(N_REQ);

  arb_state_e       state, state_n;
  logic [IW-1:0]    ptr, ptr_n;
  logic [IW-1:0]    win, win_n;
  logic             lat_we, lat_we_n;
  logic [N_REQ-1:0] gnt_n, done_n;
  logic [DW-1:0]    rdata_n, ram_wdata_n;
  logic [AW-1:0]    ram_ad_n;
  logic             ram_we_n, ram_re_n, busy_n;

  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_oh),
    .idx (pick_idx),
    .any (pick_any)
  );

  // State, pointer, latched request and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      win       <= '0;
      lat_we    <= 1'b0;
      gnt       <= '0;
      done      <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      ram_ad    <= '0;
      ram_we    <= 1'b0;
      ram_re    <= 1'b0;
      ram_wdata <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      win       <= win_n;
      lat_we    <= lat_we_n;
      gnt       <= gnt_n;
      done      <= done_n;
      rdata     <= rdata_n;
      busy      <= busy_n;
      ram_ad    <= ram_ad_n;
      ram_we    <= ram_we_n;
      ram_re    <= ram_re_n;
      ram_wdata <= ram_wdata_n;
    end
  end

  // Next state and next values of the registered outputs; the request is
  // sampled only on the IDLE -> ACCESS transition.
  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    win_n       = win;
    lat_we_n    = lat_we;
    gnt_n       = gnt;
    done_n      = '0;
    rdata_n     = rdata;
    ram_ad_n    = ram_ad;
    ram_wdata_n = ram_wdata;
    ram_we_n    = 1'b0;
    ram_re_n    = 1'b0;

    case (state)
      ST_IDLE: begin
        gnt_n = '0;
        if (pick_any) begin
          state_n     = ST_ACCESS;
          win_n       = pick_idx;
          lat_we_n    = req_we[pick_idx];
          gnt_n       = pick_oh;
          ram_ad_n    = req_ad[AW*32'(pick_idx) +: AW];
          ram_wdata_n = req_wdata[DW*32'(pick_idx) +: DW];
          ram_we_n    = req_we[pick_idx];
          ram_re_n    = !req_we[pick_idx];
        end
      end
      ST_ACCESS: begin
        // writes complete directly; reads wait one cycle for the RAM register
        if (lat_we) begin
          state_n     = ST_DONE;
          done_n[win] = 1'b1;
        end else begin
          state_n = ST_WAIT;
        end
      end
      ST_WAIT: begin
        state_n     = ST_DONE;
        done_n[win] = 1'b1;
        rdata_n     = ram_rdata;
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        gnt_n   = '0;
        ptr_n   = (win == IW'(N_REQ - 1)) ? '0 : win + IW'(1);
      end
      default: begin
        state_n = ST_IDLE;
        gnt_n   = '0;
      end
    endcase

    busy_n = (state_n != ST_IDLE);
  end

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Self-checking bench for ram_rr_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level reference model.
module tb_ram_rr_arbiter;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic [3:0]   req, req_we;
  logic [15:0]  req_ad;
  logic [31:0]  req_wdata;
  logic [3:0]   gnt, done;
  logic [7:0]   rdata, ram_wdata, ram_rdata;
  logic         busy, ram_we, ram_re;
  logic [3:0]   ram_ad;
  logic [7:0]   mem [16];

  int total = 0;
  int bad   = 0;

  ram_rr_arbiter #(.N_REQ(4), .AW(4), .DW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_we    (req_we),
    .req_ad    (req_ad),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .rdata     (rdata),
    .busy      (busy),
    .ram_ad    (ram_ad),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 16x8 RAM with registered read
  always @(posedge clk) begin
    if (ram_we) mem[ram_ad] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_ad];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // round-robin rule: first requester at or after p, wrapping
  function automatic int pick(input logic [3:0] r, input int p);
    for (int j = 0; j < N; j++) if (r[(p + j) % N]) return (p + j) % N;
    return -1;
  endfunction

  task automatic post(input int i, input logic we, input logic [3:0] ad, input logic [7:0] wd);
    req[i]             = 1'b1;
    req_we[i]          = we;
    req_ad[i*4 +: 4]   = ad;
    req_wdata[i*8 +: 8] = wd;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = '0; req_we = '0; req_ad = '0; req_wdata = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({gnt, done, rdata, busy, ram_ad, ram_we, ram_re, ram_wdata} !== 34'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {gnt, done, rdata, busy, ram_ad, ram_we, ram_re, ram_wdata});
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || gnt !== 4'd0) begin bad++; $display("FAIL reset_idle busy=%b gnt=%b want 0/0", busy, gnt); end
  endtask

  task automatic test_write_read();
    post(2, 1'b1, 4'h3, 8'hA5);
    @(negedge clk);
    total++;
    if ({gnt, ram_we, ram_re, ram_ad, ram_wdata, busy, done} !== {4'b0100, 1'b1, 1'b0, 4'h3, 8'hA5, 1'b1, 4'b0000}) begin
      bad++; $display("FAIL wr_access gnt=%b we=%b re=%b ad=%h wd=%h busy=%b done=%b", gnt, ram_we, ram_re, ram_ad, ram_wdata, busy, done);
    end
    @(negedge clk);
    total++;
    if ({done, gnt, ram_we} !== {4'b0100, 4'b0100, 1'b0}) begin
      bad++; $display("FAIL wr_done done=%b gnt=%b we=%b want 0100/0100/0", done, gnt, ram_we);
    end
    req[2] = 1'b0;
    @(negedge clk);
    total++;
    if ({gnt, busy, done} !== 9'd0) begin bad++; $display("FAIL wr_idle gnt=%b busy=%b done=%b want 0", gnt, busy, done); end
    post(2, 1'b0, 4'h3, 8'h00);
    @(negedge clk);
    total++;
    if ({ram_re, ram_we, gnt, ram_ad} !== {1'b1, 1'b0, 4'b0100, 4'h3}) begin
      bad++; $display("FAIL rd_access re=%b we=%b gnt=%b ad=%h", ram_re, ram_we, gnt, ram_ad);
    end
    @(negedge clk);
    total++;
    if ({ram_re, done, busy, gnt} !== {1'b0, 4'b0000, 1'b1, 4'b0100}) begin
      bad++; $display("FAIL rd_wait re=%b done=%b busy=%b gnt=%b", ram_re, done, busy, gnt);
    end
    @(negedge clk);
    total++;
    if (done !== 4'b0100 || rdata !== 8'hA5) begin bad++; $display("FAIL rd_done done=%b rdata=%h want 0100/a5", done, rdata); end
    req[2] = 1'b0;
    @(negedge clk);
    total++;
    if (done !== 4'd0 || rdata !== 8'hA5) begin bad++; $display("FAIL rd_hold done=%b rdata=%h want 0000/a5", done, rdata); end
  endtask

  // Pointer sits at 3 here; a reset in WAIT must clear everything including ptr.
  task automatic test_reset_mid();
    post(3, 1'b0, 4'h3, 8'h00);
    @(negedge clk);
    total++;
    if (gnt !== 4'b1000 || ram_re !== 1'b1) begin bad++; $display("FAIL rst_mid_grant gnt=%b re=%b want 1000/1", gnt, ram_re); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({gnt, done, rdata, busy, ram_ad, ram_we, ram_re, ram_wdata} !== 34'd0) begin
      bad++; $display("FAIL rst_async got=%h want=0", {gnt, done, rdata, busy, ram_ad, ram_we, ram_re, ram_wdata});
    end
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (done !== 4'd0 || busy !== 1'b0) begin bad++; $display("FAIL rst_no_done done=%b busy=%b want 0", done, busy); end
    post(1, 1'b0, 4'h3, 8'h00);
    post(3, 1'b0, 4'h3, 8'h00);
    @(negedge clk);
    total++;
    if (gnt !== 4'b0010) begin bad++; $display("FAIL rst_ptr_zero gnt=%b want 0010", gnt); end
    req[3] = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (done !== 4'b0010 || rdata !== 8'hA5) begin bad++; $display("FAIL rst_after_read done=%b rdata=%h want 0010/a5", done, rdata); end
    req[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int g = 0;
    int last_acc = -1;
    logic [3:0] prev_g = '0;
    rst = 1'b1;
    for (int i = 0; i < N; i++) post(i, 1'b1, 4'(i), 8'(8'h10 + i));
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 60 && g < 8; c++) begin
      @(negedge clk);
      if (gnt !== 4'd0 && prev_g === 4'd0) begin
        total++;
        if (gnt !== 4'(1 << (g % N))) begin bad++; $display("FAIL rr_order grant#%0d gnt=%b want %b", g, gnt, 4'(1 << (g % N))); end
        if (last_acc >= 0) begin
          total++;
          if (c - last_acc != 3) begin bad++; $display("FAIL rr_gap grant#%0d gap=%0d want 3", g, c - last_acc); end
        end
        last_acc = c;
        g++;
      end
      prev_g = gnt;
    end
    total++;
    if (g != 8) begin bad++; $display("FAIL rr_timeout grants=%0d want 8", g); end
    req = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_ptr_wrap();
    post(2, 1'b1, 4'hE, 8'h11);
    @(negedge clk);
    total++;
    if (gnt !== 4'b0100) begin bad++; $display("FAIL wrap_first gnt=%b want 0100", gnt); end
    post(0, 1'b1, 4'h6, 8'h77);
    post(3, 1'b1, 4'h5, 8'h3C);
    @(negedge clk);
    req[2] = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (gnt !== 4'b1000 || ram_ad !== 4'h5) begin bad++; $display("FAIL wrap_3_first gnt=%b ad=%h want 1000/5", gnt, ram_ad); end
    @(negedge clk);
    req[3] = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (gnt !== 4'b0001 || ram_ad !== 4'h6) begin bad++; $display("FAIL wrap_0_next gnt=%b ad=%h want 0001/6", gnt, ram_ad); end
    @(negedge clk);
    req[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_input_change();
    post(1, 1'b0, 4'h5, 8'h00);
    @(negedge clk);
    total++;
    if ({gnt, ram_re, ram_ad} !== {4'b0010, 1'b1, 4'h5}) begin bad++; $display("FAIL chg_access gnt=%b re=%b ad=%h", gnt, ram_re, ram_ad); end
    req_ad[4 +: 4] = 4'h9;
    req_we[1]      = 1'b1;
    @(negedge clk);
    total++;
    if ({ram_ad, ram_we, ram_re} !== {4'h5, 1'b0, 1'b0}) begin bad++; $display("FAIL chg_wait ad=%h we=%b re=%b want 5/0/0", ram_ad, ram_we, ram_re); end
    req[1] = 1'b0;
    @(negedge clk);
    total++;
    if (done !== 4'b0010 || rdata !== 8'h3C) begin bad++; $display("FAIL chg_done done=%b rdata=%h want 0010/3c", done, rdata); end
    @(negedge clk);
    total++;
    if (gnt !== 4'd0 || done !== 4'd0) begin bad++; $display("FAIL chg_idle gnt=%b done=%b want 0", gnt, done); end
  endtask

  // Random traffic: k = cycle position within the current transaction
  // (0 = idle cycle, 1 = strobe cycle, L = done cycle; L = 2 write, 3 read).
  task automatic test_random();
    logic [3:0]  pend = '0;
    logic [7:0]  emem [16];
    logic [15:0] evalid = '0;
    logic [7:0]  exp_rd = '0;
    logic [3:0]  exp_g;
    int k = 0, L = 2, w = 0, ptr_m = 0;
    logic w_we = 1'b0;
    logic [3:0] w_ad = '0;
    logic [7:0] w_wd = '0;
    logic nwe;
    logic [3:0] nad;
    req = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (k == 0) begin
        if (req != 4'd0) begin
          w    = pick(req, ptr_m);
          k    = 1;
          w_we = req_we[w];
          w_ad = req_ad[w*4 +: 4];
          w_wd = req_wdata[w*8 +: 8];
          L    = w_we ? 2 : 3;
          if (w_we) begin emem[w_ad] = w_wd; evalid[w_ad] = 1'b1; end
        end
      end else if (k == L) begin
        k = 0;
        ptr_m = (w + 1) % N;
      end else begin
        k++;
        if (k == L && !w_we) exp_rd = emem[w_ad];
      end

      exp_g = (k == 0) ? 4'd0 : 4'(1 << w);
      total++;
      if (gnt !== exp_g) begin bad++; $display("FAIL rnd_gnt c=%0d got=%b want=%b", c, gnt, exp_g); end
      total++;
      if (done !== ((k != 0 && k == L) ? exp_g : 4'd0)) begin bad++; $display("FAIL rnd_done c=%0d got=%b k=%0d", c, done, k); end
      total++;
      if (busy !== (k != 0)) begin bad++; $display("FAIL rnd_busy c=%0d got=%b want=%b", c, busy, k != 0); end
      total++;
      if ({ram_we, ram_re} !== {k == 1 && w_we, k == 1 && !w_we}) begin
        bad++; $display("FAIL rnd_strobe c=%0d we=%b re=%b k=%0d wwe=%b", c, ram_we, ram_re, k, w_we);
      end
      if (k == 1) begin
        total++;
        if (ram_ad !== w_ad || (w_we && ram_wdata !== w_wd)) begin
          bad++; $display("FAIL rnd_port c=%0d ad=%h wd=%h want %h/%h", c, ram_ad, ram_wdata, w_ad, w_wd);
        end
      end
      total++;
      if (rdata !== exp_rd) begin bad++; $display("FAIL rnd_rdata c=%0d got=%h want=%h", c, rdata, exp_rd); end
      total++;
      if ((ram_we & ram_re) !== 1'b0 || !$onehot0(gnt)) begin
        bad++; $display("FAIL rnd_excl c=%0d we=%b re=%b gnt=%b", c, ram_we, ram_re, gnt);
      end

      if (k != 0 && k == L) begin pend[w] = 1'b0; req[w] = 1'b0; end
      if (k >= 1 && k < L) begin
        if ($urandom_range(3) == 0) req[w] = 1'b0;
        if ($urandom_range(1) == 0) begin
          req_ad[w*4 +: 4]    = 4'($urandom);
          req_wdata[w*8 +: 8] = 8'($urandom);
          req_we[w]           = 1'($urandom);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && c < 540 && $urandom_range(2) == 0) begin
          nad = 4'($urandom);
          nwe = 1'($urandom);
          if (!evalid[nad]) nwe = 1'b1;
          pend[i] = 1'b1;
          post(i, nwe, nad, 8'($urandom));
        end
      end
    end
    total++;
    if (pend !== 4'd0) begin bad++; $display("FAIL rnd_drain pending=%b want 0000", pend); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_reset_mid();
    test_round_robin();
    test_ptr_wrap();
    test_input_change();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
